instruction_fetch: RTL and testbench

//  COMET II instruction fetch stage, directly downstream of Program_RAM. Walks the PC,

---
 rtl/comet2_pkg.sv | 28 ++
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/comet2_pkg.sv
// rtl/comet2_pkg.sv - COMET II fetch state encoding, opcode constants and instruction length rule
package comet2_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE  = 3'd0,
        FETCH_F1    = 3'd1,
        FETCH_F2    = 3'd2,
        FETCH_ISSUE = 3'd3,
        FETCH_HALT  = 3'd4
    } fetch_state_e;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_POP = 8'h71;
    localparam logic [7:0] OP_RET = 8'h81;
    localparam logic [7:0] OP_SVC = 8'hF0;

    // Register-register forms of the 1x..4x groups set bit 2; their memory forms carry an adr word.
    function automatic logic is_two_word(input logic [7:0] opcode);
        logic one_word;
        one_word = (opcode == OP_NOP) || (opcode == OP_POP) || (opcode == OP_RET) ||
                   ((opcode[7:4] >= 4'h1) && (opcode[7:4] <= 4'h4) && opcode[2]);
        if (opcode == OP_SVC) begin
            one_word = 1'b0;
        end
        return !one_word;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - COMET II fetch stage: PC walk, 1/2-word fetch, decode handshake
// Optional breakpoint halt enabled by defining IFETCH_BKPT_EN.
module instruction_fetch
    import comet2_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        mclk,
    input  logic        reset,
    input  logic        run,
    output logic        mem_re,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        jump_en,
    input  logic [15:0] jump_addr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_ir0,
    output logic [15:0] out_ir1,
    output logic        out_len2,
    output logic [15:0] out_pc,
    output logic        halted
`ifdef IFETCH_BKPT_EN
    ,
    input  logic        bkpt_en,
    input  logic [15:0] bkpt_addr
`endif
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  ir0_q, ir0_d;
    logic [15:0]  ir1_q, ir1_d;
    logic         len2_q, len2_d;
    logic [15:0]  opc_q, opc_d;
    logic         bkpt_hit;

`ifdef IFETCH_BKPT_EN
    assign bkpt_hit = bkpt_en && (pc_q == bkpt_addr);
`else
    assign bkpt_hit = 1'b0;
`endif

    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH_IDLE;
            pc_q    <= RESET_PC;
            ir0_q   <= 16'h0000;
            ir1_q   <= 16'h0000;
            len2_q  <= 1'b0;
            opc_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir0_q   <= ir0_d;
            ir1_q   <= ir1_d;
            len2_q  <= len2_d;
            opc_q   <= opc_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir0_d     = ir0_q;
        ir1_d     = ir1_q;
        len2_d    = len2_q;
        opc_d     = opc_q;
        mem_re    = 1'b0;
        mem_raddr = pc_q;
        out_valid = 1'b0;

        case (state_q)
            FETCH_IDLE: begin
                if (jump_en) begin
                    pc_d = jump_addr;
                end
                if (run) begin
                    state_d = FETCH_F1;
                end
            end

            FETCH_F1: begin
                mem_re = !bkpt_hit;
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = FETCH_F1;
                end else if (bkpt_hit) begin
                    state_d = FETCH_HALT;
                end else begin
                    ir0_d   = mem_rdata;
                    opc_d   = pc_q;
                    len2_d  = is_two_word(mem_rdata[15:8]);
                    pc_d    = pc_q + 16'd1;
                    state_d = is_two_word(mem_rdata[15:8]) ? FETCH_F2 : FETCH_ISSUE;
                end
            end

            FETCH_F2: begin
                mem_re = 1'b1;
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = FETCH_F1;
                end else begin
                    ir1_d   = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = FETCH_ISSUE;
                end
            end

            FETCH_ISSUE: begin
                // A redirect in the same cycle kills the handoff so decode never sees a stale instruction.
                out_valid = !jump_en;
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = FETCH_F1;
                end else if (out_ready) begin
                    state_d = FETCH_F1;
                end
            end

`ifdef IFETCH_BKPT_EN
            FETCH_HALT: begin
                if (jump_en) begin
                    pc_d    = jump_addr;
                    state_d = FETCH_F1;
                end
            end
`endif

            default: begin
                state_d = FETCH_IDLE;
            end
        endcase
    end

    assign out_ir0  = ir0_q;
    assign out_ir1  = ir1_q;
    assign out_len2 = len2_q;
    assign out_pc   = opc_q;

`ifdef IFETCH_BKPT_EN
    assign halted = (state_q == FETCH_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against an instruction-stream model
module tb_instruction_fetch;

    logic        mclk = 1'b0;
    logic        reset, run, mem_re, jump_en, out_valid, out_ready, out_len2, halted;
    logic [15:0] mem_raddr, mem_rdata, jump_addr, out_ir0, out_ir1, out_pc;
`ifdef IFETCH_BKPT_EN
    logic        bkpt_en;
    logic [15:0] bkpt_addr;
`endif

    logic [15:0] ram [0:65535];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 mclk = ~mclk;
    assign mem_rdata = ram[mem_raddr];

    instruction_fetch #(.RESET_PC(16'h0000)) dut (
        .mclk(mclk), .reset(reset), .run(run),
        .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .jump_en(jump_en), .jump_addr(jump_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir0(out_ir0), .out_ir1(out_ir1), .out_len2(out_len2), .out_pc(out_pc),
        .halted(halted)
`ifdef IFETCH_BKPT_EN
        , .bkpt_en(bkpt_en), .bkpt_addr(bkpt_addr)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge mclk);
        #2;
    endtask

    // Instruction length straight from the ISA table: short forms are NOP, POP, RET and reg-reg 1x..4x.
    function automatic int ref_len(input logic [15:0] w);
        int op;
        op = int'(w[15:8]);
        if (op == 'h00 || op == 'h71 || op == 'h81) return 1;
        if (op >= 'h10 && op < 'h50 && (op % 8) >= 4) return 1;
        return 2;
    endfunction

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; jump_en = 1'b0; jump_addr = 16'h0000; out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    logic [15:0] mpc, s_ir0, s_ir1, s_pc;
    logic        s_len2, hold, bad_read;
    int          n_xfer, len;

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 16'h0000;
`ifdef IFETCH_BKPT_EN
        bkpt_en = 1'b0; bkpt_addr = 16'h0000;
`endif
        reset = 1'b1; run = 1'b0; jump_en = 1'b0; jump_addr = 16'h0000; out_ready = 1'b0;
        #1;
        check_eq("rst_valid", out_valid, 0);
        check_eq("rst_halted", halted, 0);
        check_eq("rst_pc", out_pc, 16'h0000);
        check_eq("rst_ir0", out_ir0, 16'h0000);
        check_eq("rst_len2", out_len2, 0);
        check_eq("rst_raddr", mem_raddr, 16'h0000);
        do_reset();

        ram[0] = 16'h1400; ram[1] = 16'h1010; ram[2] = 16'h0070; ram[3] = 16'h1400;
        ram[4] = 16'h1010; ram[16'h0060] = 16'h1400;
        run = 1'b1; out_ready = 1'b1;
        step();
        check_eq("t1_f1_re", mem_re, 1);
        check_eq("t1_f1_addr", mem_raddr, 16'h0000);
        step();
        check_eq("t1_valid", out_valid, 1);
        check_eq("t1_ir0", out_ir0, 16'h1400);
        check_eq("t1_len2", out_len2, 0);
        check_eq("t1_pc", out_pc, 16'h0000);
        check_eq("t1_issue_re", mem_re, 0);
        step();
        check_eq("t1_next_addr", mem_raddr, 16'h0001);
        check_eq("t1_next_re", mem_re, 1);
        step();
        check_eq("t2_f2_addr", mem_raddr, 16'h0002);
        out_ready = 1'b0;
        step();
        check_eq("t2_valid", out_valid, 1);
        check_eq("t2_ir0", out_ir0, 16'h1010);
        check_eq("t2_ir1", out_ir1, 16'h0070);
        check_eq("t2_len2", out_len2, 1);
        check_eq("t2_pc", out_pc, 16'h0001);

        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("t3_valid", out_valid, 1);
            check_eq("t3_ir0", out_ir0, 16'h1010);
            check_eq("t3_ir1", out_ir1, 16'h0070);
            check_eq("t3_re", mem_re, 0);
            check_eq("t3_pc_hold", mem_raddr, 16'h0003);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("t3_after_valid", out_valid, 0);
        check_eq("t3_after_addr", mem_raddr, 16'h0003);
        step();
        check_eq("t3_one_xfer", out_pc, 16'h0003);

        out_ready = 1'b1;
        step();
        check_eq("t4_f1_addr", mem_raddr, 16'h0004);
        step();
        check_eq("t4_f2_addr", mem_raddr, 16'h0005);
        jump_en = 1'b1; jump_addr = 16'h0060;
        step();
        jump_en = 1'b0;
        check_eq("t4_no_valid", out_valid, 0);
        check_eq("t4_redirect", mem_raddr, 16'h0060);
        out_ready = 1'b0;
        step();
        check_eq("t4_new_valid", out_valid, 1);
        check_eq("t4_new_pc", out_pc, 16'h0060);

        ram[16'hFFFF] = 16'h6400; ram[0] = 16'h0010;
        jump_en = 1'b1; jump_addr = 16'hFFFF;
        #1;
        check_eq("t5_gate", out_valid, 0);
        step();
        jump_en = 1'b0;
        check_eq("t5_f1_addr", mem_raddr, 16'hFFFF);
        step();
        check_eq("t5_wrap_addr", mem_raddr, 16'h0000);
        step();
        check_eq("t5_ir0", out_ir0, 16'h6400);
        check_eq("t5_ir1", out_ir1, 16'h0010);
        check_eq("t5_len2", out_len2, 1);
        check_eq("t5_pc", out_pc, 16'hFFFF);
        check_eq("t5_pc_wrap", mem_raddr, 16'h0001);

        ram[1] = 16'h1010;
        out_ready = 1'b1;
        step();
        step();
        check_eq("t6_in_f2", mem_raddr, 16'h0002);
        reset = 1'b1;
        #1;
        check_eq("t6_valid", out_valid, 0);
        check_eq("t6_pc", mem_raddr, 16'h0000);
        check_eq("t6_re", mem_re, 0);
        step();
        reset = 1'b0;
        run = 1'b0;

`ifdef IFETCH_BKPT_EN
        ram[0] = 16'h1400; ram[1] = 16'h1400; ram[2] = 16'h1400; ram[3] = 16'h1400;
        do_reset();
        bkpt_en = 1'b1; bkpt_addr = 16'h0003; run = 1'b1; out_ready = 1'b1;
        bad_read = 1'b0;
        for (int i = 0; i < 40 && !halted; i++) begin
            step();
            if (mem_re && mem_raddr == 16'h0003) bad_read = 1'b1;
        end
        check_eq("bk_halted", halted, 1);
        check_eq("bk_no_read", bad_read, 0);
        jump_en = 1'b1; jump_addr = 16'h0000;
        step();
        jump_en = 1'b0;
        check_eq("bk_exit", halted, 0);
        check_eq("bk_exit_addr", mem_raddr, 16'h0000);
        bkpt_en = 1'b0;
`endif

        for (int i = 0; i < 65536; i++) begin
            if ($urandom_range(1, 0) == 1)
                ram[i] = {8'h10 + 8'($urandom_range(3, 0) * 16) + 8'h04 + 8'($urandom_range(3, 0)), 8'($urandom)};
            else
                ram[i] = 16'($urandom);
        end
        do_reset();
        run = 1'b1;
        mpc = 16'h0000; hold = 1'b0; n_xfer = 0;
        s_ir0 = 0; s_ir1 = 0; s_pc = 0; s_len2 = 0;
        for (int c = 0; c < 4000; c++) begin
            step();
            jump_en = ($urandom_range(19, 0) == 0);
            case ($urandom_range(3, 0))
                0: jump_addr = 16'hFFFE + 16'($urandom_range(1, 0));
                default: jump_addr = 16'($urandom);
            endcase
            out_ready = ($urandom_range(9, 0) < 7);
            #1;
            if (jump_en) begin
                check_eq("rnd_gate", out_valid, 0);
            end else if (hold) begin
                check_eq("rnd_hold_valid", out_valid, 1);
                check_eq("rnd_hold_pc", out_pc, s_pc);
                check_eq("rnd_hold_ir0", out_ir0, s_ir0);
                check_eq("rnd_hold_len2", out_len2, s_len2);
                if (s_len2) check_eq("rnd_hold_ir1", out_ir1, s_ir1);
            end
            if (out_valid && out_ready) begin
                len = ref_len(ram[mpc]);
                check_eq("rnd_pc", out_pc, mpc);
                check_eq("rnd_ir0", out_ir0, ram[mpc]);
                check_eq("rnd_len2", out_len2, (len == 2));
                if (len == 2) check_eq("rnd_ir1", out_ir1, ram[16'(mpc + 16'd1)]);
                mpc = 16'(mpc + 16'(len));
                n_xfer++;
            end
            hold = out_valid && !out_ready && !jump_en;
            s_ir0 = out_ir0; s_ir1 = out_ir1; s_pc = out_pc; s_len2 = out_len2;
            if (jump_en) mpc = jump_addr;
        end
        check_eq("rnd_progress", (n_xfer > 300), 1);
        check_eq("rnd_halted", halted, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
